// File: rtl/disaster_alert_scheduler.sv
// disaster_alert_scheduler
//   Sequences four latched hazard alarms (flood, cyclone, earthquake,
//   tsunami) onto a one-hot LED bank and an audible buzzer.
//   Each raw detection is debounced, then latched until the operator
//   acknowledges it. The LED bank shows either the single highest-priority
//   alarm (priority mode) or cycles through all alarms (scan mode).
//
// Ports
//   clk     in   1  clock, all state on rising edge
//   rst_n   in   1  asynchronous active-low reset
//   det     in   4  raw detections [0]=flood [1]=cyclone [2]=earthquake [3]=tsunami
//   mode    in   1  0 = priority display, 1 = scan display
//   ack     in   1  operator acknowledge (pulse or level)
//   alarm   out  4  latched alarm vector, same bit order as det
//   led     out  4  one-hot (or zero) LED drive
//   buzzer  out  1  square-wave audible alert
//   busy    out  1  high while any alarm bit is set
module disaster_alert_scheduler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] det,
    input  logic       mode,
    input  logic       ack,
    output logic [3:0] alarm,
    output logic [3:0] led,
    output logic       buzzer,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRIO, SCAN} state_t;

    state_t             state_q, state_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [3:0]         alarm_q, alarm_d;
    logic               busy_q;
    logic [1:0]         cur_q, cur_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [3:0]         led_q, led_d;
    logic [DW-1:0]      bcnt_q, bcnt_d;
    logic               buzzer_q, buzzer_d;
    logic               silenced_q, silenced_d;
    logic [3:0]         set_v;
    logic [3:0]         clr_v;

    // Lowest set index wins: flood is the highest priority.
    function automatic logic [1:0] prio_idx(input logic [3:0] a);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (a[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, wrapping 3->0; falls back to cur
    // itself when it is the only set bit.
    function automatic logic [1:0] next_idx(input logic [3:0] a, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] idx;
        r = cur;
        for (int k = 3; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (a[idx]) r = idx;
        end
        return r;
    endfunction

    // Debounce and alarm latch. A set needs det high, so it can never
    // coincide with an ack-clear of the same bit; the OR still makes set win.
    always_comb begin
        set_v = 4'b0;
        clr_v = 4'b0;
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (!det[i]) begin
                cnt_d[i] = '0;
                clr_v[i] = ack;
            end else begin
                if (cnt_q[i] == DB_LAST) set_v[i] = 1'b1;
                if (cnt_q[i] != DB_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        alarm_d = (alarm_q & ~clr_v) | set_v;
    end

    // Silencing: a fresh alarm or a fully cleared bank re-arms the buzzer.
    always_comb begin
        silenced_d = silenced_q;
        if (((set_v & ~alarm_q) != 4'b0) || (alarm_d == 4'b0)) begin
            silenced_d = 1'b0;
        end else if (ack) begin
            silenced_d = 1'b1;
        end
    end

    // Buzzer: half-period of DWELL_CYCLES; ack mutes it on the very next edge.
    always_comb begin
        buzzer_d = buzzer_q;
        bcnt_d   = bcnt_q;
        if (!busy_q || silenced_q || ack) begin
            buzzer_d = 1'b0;
            bcnt_d   = '0;
        end else if (bcnt_q == DWELL_LAST) begin
            buzzer_d = ~buzzer_q;
            bcnt_d   = '0;
        end else begin
            bcnt_d = bcnt_q + DW'(1);
        end
    end

    // Display FSM works from the registered alarm, giving one edge of latency.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
        led_d   = 4'b0;
        case (state_q)
            IDLE, PRIO: begin
                dwell_d = '0;
                if (alarm_q == 4'b0) begin
                    state_d = IDLE;
                end else if (mode) begin
                    state_d = SCAN;
                    cur_d   = prio_idx(alarm_q);
                    led_d   = 4'b0001 << cur_d;
                end else begin
                    state_d = PRIO;
                    led_d   = 4'b0001 << prio_idx(alarm_q);
                end
            end
            SCAN: begin
                if (alarm_q == 4'b0) begin
                    state_d = IDLE;
                    dwell_d = '0;
                end else if (!mode) begin
                    state_d = PRIO;
                    dwell_d = '0;
                    led_d   = 4'b0001 << prio_idx(alarm_q);
                end else begin
                    if (!alarm_q[cur_q] || (dwell_q == DWELL_LAST)) begin
                        cur_d   = next_idx(alarm_q, cur_q);
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                    led_d = 4'b0001 << cur_d;
                end
            end
            default: begin
                state_d = IDLE;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alarm_q    <= 4'b0;
            busy_q     <= 1'b0;
            cur_q      <= 2'd0;
            dwell_q    <= '0;
            led_q      <= 4'b0;
            bcnt_q     <= '0;
            buzzer_q   <= 1'b0;
            silenced_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alarm_q    <= alarm_d;
            busy_q     <= |alarm_d;
            cur_q      <= cur_d;
            dwell_q    <= dwell_d;
            led_q      <= led_d;
            bcnt_q     <= bcnt_d;
            buzzer_q   <= buzzer_d;
            silenced_q <= silenced_d;
        end
    end

    assign alarm  = alarm_q;
    assign led    = led_q;
    assign buzzer = buzzer_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_disaster_alert_scheduler.sv
// Directed bench for disaster_alert_scheduler (DEBOUNCE_CYCLES=4, DWELL_CYCLES=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_disaster_alert_scheduler;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] det   = 4'b0;
    logic       mode  = 1'b0;
    logic       ack   = 1'b0;
    logic [3:0] alarm;
    logic [3:0] led;
    logic       buzzer;
    logic       busy;

    int checks = 0;
    int errors = 0;

    disaster_alert_scheduler #(
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .det   (det),
        .mode  (mode),
        .ack   (ack),
        .alarm (alarm),
        .led   (led),
        .buzzer(buzzer),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        check_eq("rst_alarm", 32'(alarm), 32'h0);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_buzzer", 32'(buzzer), 32'h0);
        tick(1);
        rst_n = 1'b1;

        // 1: three-cycle glitch must not latch
        det = 4'b0001;
        tick(3);
        det = 4'b0000;
        tick(1);
        check_eq("t1_alarm", 32'(alarm), 32'h0);
        check_eq("t1_led", 32'(led), 32'h0);
        tick(2);
        check_eq("t1_led_late", 32'(led), 32'h0);

        // 2: four-cycle detection latches, LED one edge later, buzzer half-period 8
        det = 4'b0001;
        tick(3);
        check_eq("t2_alarm_e3", 32'(alarm), 32'h0);
        tick(1);
        check_eq("t2_alarm_e4", 32'(alarm), 32'h1);
        check_eq("t2_led_e4", 32'(led), 32'h0);
        check_eq("t2_busy", 32'(busy), 32'h1);
        tick(1);
        check_eq("t2_led_e5", 32'(led), 32'h1);
        tick(6);
        check_eq("t2_buz_e11", 32'(buzzer), 32'h0);
        tick(1);
        check_eq("t2_buz_e12", 32'(buzzer), 32'h1);
        tick(7);
        check_eq("t2_buz_e19", 32'(buzzer), 32'h1);
        tick(1);
        check_eq("t2_buz_e20", 32'(buzzer), 32'h0);

        // clear everything
        det = 4'b0000;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_eq("clr_alarm", 32'(alarm), 32'h0);
        check_eq("clr_busy", 32'(busy), 32'h0);
        tick(1);
        check_eq("clr_led", 32'(led), 32'h0);

        // 3: priority mode
        mode = 1'b0;
        det  = 4'b1100;
        tick(4);
        check_eq("t3_alarm", 32'(alarm), 32'hC);
        tick(1);
        check_eq("t3_led_eq", 32'(led), 32'h4);
        det = 4'b1101;
        tick(4);
        check_eq("t3_alarm_fl", 32'(alarm), 32'hD);
        check_eq("t3_led_old", 32'(led), 32'h4);
        tick(1);
        check_eq("t3_led_fl", 32'(led), 32'h1);
        det = 4'b0101;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_eq("t3_ack_alarm", 32'(alarm), 32'h5);
        check_eq("t3_ack_buz", 32'(buzzer), 32'h0);
        tick(10);
        check_eq("t3_silenced", 32'(buzzer), 32'h0);
        check_eq("t3_led_keep", 32'(led), 32'h1);

        // clear before scan test
        det = 4'b0000;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
        check_eq("clr2_led", 32'(led), 32'h0);

        // 4: scan mode round-robin of 1011
        mode = 1'b1;
        det  = 4'b1011;
        tick(4);
        check_eq("t4_alarm", 32'(alarm), 32'hB);
        tick(1);
        check_eq("t4_led_e5", 32'(led), 32'h1);
        tick(7);
        check_eq("t4_led_e12", 32'(led), 32'h1);
        tick(1);
        check_eq("t4_led_e13", 32'(led), 32'h2);
        tick(7);
        check_eq("t4_led_e20", 32'(led), 32'h2);
        tick(1);
        check_eq("t4_led_e21", 32'(led), 32'h8);
        tick(7);
        check_eq("t4_led_e28", 32'(led), 32'h8);
        tick(1);
        check_eq("t4_led_wrap", 32'(led), 32'h1);
        det = 4'b1010;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_eq("t4_ack_alarm", 32'(alarm), 32'hA);
        check_eq("t4_ack_led", 32'(led), 32'h1);
        tick(1);
        check_eq("t4_adv_led", 32'(led), 32'h2);

        // 5: new latch after ack re-arms the buzzer
        tick(3);
        check_eq("t5_mute", 32'(buzzer), 32'h0);
        det = 4'b1110;
        tick(4);
        check_eq("t5_alarm", 32'(alarm), 32'hE);
        tick(7);
        check_eq("t5_buz_pre", 32'(buzzer), 32'h0);
        tick(1);
        check_eq("t5_buz_on", 32'(buzzer), 32'h1);
        det = 4'b0000;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check_eq("t5_alarm_clr", 32'(alarm), 32'h0);
        check_eq("t5_busy_clr", 32'(busy), 32'h0);
        check_eq("t5_buz_clr", 32'(buzzer), 32'h0);
        tick(1);
        check_eq("t5_led_idle", 32'(led), 32'h0);

        // 6: asynchronous reset mid-scan, then full debounce again
        det = 4'b0011;
        tick(5);
        check_eq("t6_led_pre", 32'(led), 32'h1);
        check_eq("t6_alarm_pre", 32'(alarm), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_alarm", 32'(alarm), 32'h0);
        check_eq("t6_rst_led", 32'(led), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        check_eq("t6_rst_buz", 32'(buzzer), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check_eq("t6_relatch_e3", 32'(alarm), 32'h0);
        tick(1);
        check_eq("t6_relatch_e4", 32'(alarm), 32'h3);
        tick(1);
        check_eq("t6_led_post", 32'(led), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
